muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_unit.sv | 114 +++++++++++
 tb/tb_muldiv_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
// Holds the operation encodings, the FSM state type, the default operand width
// and the iteration count used by muldiv_unit.
package muldiv_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int ITERS     = 16;
    localparam int CNT_W     = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply / divide with register-file write-back.
// Ports:
//   Clock, Reset_n      - rising-edge clock, asynchronous active-low reset
//   Start, Op           - request pulse and operation (MUL, MULH, DIV, REM)
//   ReadRS, ReadRT, RD  - operand A, operand B and destination register
//   Flush               - abort the operation in flight
//   Busy, Done          - unit occupied / one-cycle result strobe
//   RegWrite, WriteData, RDOut - register file write port
//   DivByZero           - flags a DIV/REM result computed with a zero divisor
// Build option: define MULDIV_REM_EN to support Op=REM; otherwise REM requests are ignored.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int REG_AW = 2
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [WIDTH-1:0]  ReadRS,
    input  logic [WIDTH-1:0]  ReadRT,
    input  logic [REG_AW-1:0] RD,
    input  logic              Flush,
    output logic              Busy,
    output logic              Done,
    output logic              RegWrite,
    output logic [WIDTH-1:0]  WriteData,
    output logic [REG_AW-1:0] RDOut,
    output logic              DivByZero
);

    state_e             state, state_nxt;
    op_e                op_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc, mq, b, wd;
    logic [REG_AW-1:0]  rd_q;
    logic [WIDTH:0]     mul_sum, div_diff;
    logic [WIDTH-1:0]   acc_nxt, mq_nxt, result;
    logic               op_ok, start_ok, last, div_ge, hi_sel;

`ifdef MULDIV_REM_EN
    assign op_ok  = 1'b1;
    assign hi_sel = (op_q == OP_MULH) || (op_q == OP_REM);
`else
    assign op_ok  = (op_e'(Op) != OP_REM);
    assign hi_sel = (op_q == OP_MULH);
`endif

    assign start_ok = Start && !Flush && op_ok;
    assign last     = (cnt == LAST_CNT);

    // {acc, mq} is one double-width register: multiply shifts it right while
    // adding the multiplicand into acc; divide shifts it left and acc holds
    // the partial remainder while quotient bits enter mq from the bottom.
    assign mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, b} : '0);
    assign div_diff = {acc, mq[WIDTH-1]} - {1'b0, b};
    assign div_ge   = !div_diff[WIDTH];
    assign acc_nxt  = op_q[1] ? (div_ge ? div_diff[WIDTH-1:0] : {acc[WIDTH-2:0], mq[WIDTH-1]})
                              : mul_sum[WIDTH:1];
    assign mq_nxt   = op_q[1] ? {mq[WIDTH-2:0], div_ge} : {mul_sum[0], mq[WIDTH-1:1]};
    assign result   = hi_sel ? acc_nxt : mq_nxt;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start_ok ? RUN : IDLE;
            RUN:     state_nxt = Flush ? IDLE : (last ? DONE : RUN);
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt  <= '0;
            acc  <= '0;
            mq   <= '0;
            b    <= '0;
            wd   <= '0;
            rd_q <= '0;
            op_q <= OP_MUL;
        end else if (state == IDLE && start_ok) begin
            cnt  <= '0;
            acc  <= '0;
            mq   <= ReadRS;
            b    <= ReadRT;
            rd_q <= RD;
            op_q <= op_e'(Op);
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            acc <= acc_nxt;
            mq  <= mq_nxt;
            if (last && !Flush)
                wd <= result;
        end
    end

    // Flush during DONE suppresses the write-back in that same cycle.
    assign Busy      = (state != IDLE);
    assign Done      = (state == DONE) && !Flush;
    assign RegWrite  = Done;
    assign DivByZero = Done && op_q[1] && (b == '0);
    assign WriteData = wd;
    assign RDOut     = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic [1:0]  Op;
    logic [15:0] ReadRS, ReadRT;
    logic [1:0]  RD;
    logic        Flush;
    logic        Busy, Done, RegWrite, DivByZero;
    logic [15:0] WriteData;
    logic [1:0]  RDOut;

    int checks = 0;
    int errors = 0;

    muldiv_unit dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Op        (Op),
        .ReadRS    (ReadRS),
        .ReadRT    (ReadRT),
        .RD        (RD),
        .Flush     (Flush),
        .Busy      (Busy),
        .Done      (Done),
        .RegWrite  (RegWrite),
        .WriteData (WriteData),
        .RDOut     (RDOut),
        .DivByZero (DivByZero)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge; the following posedge samples the request.
    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] bv, input logic [1:0] rd);
        Start = 1'b1; Op = op; ReadRS = a; ReadRT = bv; RD = rd;
        @(posedge Clock);
        #1 Start = 1'b0; ReadRS = 16'h5A5A; ReadRT = 16'hA5A5; RD = 2'd0;
    endtask

    // Returns the cycle index (after the sampling edge) where Done is seen, or 0.
    task automatic wait_done(input int base, output int cyc);
        cyc = 0;
        for (int k = base + 1; k <= base + 30; k++) begin
            @(negedge Clock);
            if (Done) begin
                cyc = k;
                return;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a, input logic [15:0] bv,
                          input logic [1:0] rd, input logic [15:0] exp, input logic exp_dbz);
        int c;
        issue(op, a, bv, rd);
        wait_done(0, c);
        check({tag, " latency"}, c, 17);
        check({tag, " data"}, WriteData, exp);
        check({tag, " rd"}, RDOut, rd);
        check({tag, " regwrite"}, RegWrite, 1);
        check({tag, " dbz"}, DivByZero, exp_dbz);
        @(negedge Clock);
        check({tag, " done low after"}, Done, 0);
        check({tag, " idle after"}, Busy, 0);
    endtask

    task automatic count_done(input int n, output int seen_done, output int seen_busy);
        seen_done = 0;
        seen_busy = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge Clock);
            if (RegWrite) seen_done++;
            if (Busy) seen_busy++;
        end
    endtask

    initial begin
        int c, nd, nb;
        Reset_n = 1'b0; Start = 1'b0; Op = 2'b00; ReadRS = '0; ReadRT = '0; RD = '0; Flush = 1'b0;
        repeat (2) @(negedge Clock);
        check("reset busy", Busy, 0);
        check("reset done", Done, 0);
        check("reset regwrite", RegWrite, 0);
        check("reset dbz", DivByZero, 0);
        check("reset wdata", WriteData, 0);
        check("reset rdout", RDOut, 0);
        Reset_n = 1'b1;

        run_op("mul", 2'b00, 16'd300, 16'd200, 2'd1, 16'hEA60, 1'b0);
        run_op("mulh", 2'b01, 16'd1000, 16'd1000, 2'd2, 16'h000F, 1'b0);
        run_op("mul max", 2'b00, 16'hFFFF, 16'hFFFF, 2'd3, 16'h0001, 1'b0);
        run_op("mulh max", 2'b01, 16'hFFFF, 16'hFFFF, 2'd0, 16'hFFFE, 1'b0);
        run_op("div", 2'b10, 16'd100, 16'd7, 2'd3, 16'd14, 1'b0);
        run_op("div by0", 2'b10, 16'd1234, 16'd0, 2'd2, 16'hFFFF, 1'b1);
        run_op("div big", 2'b10, 16'hFFFF, 16'd2, 2'd1, 16'h7FFF, 1'b0);
`ifdef MULDIV_REM_EN
        run_op("rem", 2'b11, 16'd100, 16'd7, 2'd1, 16'd2, 1'b0);
        run_op("rem by0", 2'b11, 16'd1234, 16'd0, 2'd3, 16'd1234, 1'b1);
`else
        issue(2'b11, 16'd100, 16'd7, 2'd1);
        count_done(20, nd, nb);
        check("rem off busy", nb, 0);
        check("rem off done", nd, 0);
`endif

        // Start while busy is ignored
        issue(2'b00, 16'd300, 16'd200, 2'd1);
        repeat (5) @(negedge Clock);
        check("ignore busy", Busy, 1);
        issue(2'b10, 16'd9, 16'd3, 2'd3);
        wait_done(5, c);
        check("ignore latency", c, 17);
        check("ignore data", WriteData, 16'hEA60);
        check("ignore rd", RDOut, 1);
        @(negedge Clock);

        // Flush in RUN
        issue(2'b00, 16'd3, 16'd5, 2'd2);
        repeat (8) @(negedge Clock);
        Flush = 1'b1;
        #1 check("flush run done", Done, 0);
        @(posedge Clock);
        #1 Flush = 1'b0;
        @(negedge Clock);
        check("flush run idle", Busy, 0);
        count_done(20, nd, nb);
        check("flush run no wb", nd, 0);

        // Flush in DONE
        issue(2'b00, 16'd6, 16'd7, 2'd2);
        wait_done(0, c);
        check("flush done latency", c, 17);
        Flush = 1'b1;
        #1 check("flush done strobe", Done, 0);
        check("flush done regwrite", RegWrite, 0);
        @(posedge Clock);
        #1 Flush = 1'b0;
        @(negedge Clock);
        check("flush done idle", Busy, 0);

        // Flush and Start together in IDLE
        Flush = 1'b1;
        issue(2'b00, 16'd2, 16'd2, 2'd1);
        Flush = 1'b0;
        count_done(20, nd, nb);
        check("flush+start busy", nb, 0);
        check("flush+start done", nd, 0);

        // Reset mid-operation
        issue(2'b00, 16'd300, 16'd200, 2'd3);
        repeat (10) @(negedge Clock);
        Reset_n = 1'b0;
        #1 check("async rst busy", Busy, 0);
        check("async rst wdata", WriteData, 0);
        check("async rst rdout", RDOut, 0);
        check("async rst done", Done, 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        count_done(25, nd, nb);
        check("post rst no wb", nd, 0);
        run_op("post rst mul", 2'b00, 16'd3, 16'd4, 2'd2, 16'd12, 1'b0);

        // Back-to-back: second request in the cycle after DONE
        run_op("b2b first", 2'b10, 16'd50, 16'd5, 2'd1, 16'd10, 1'b0);
        run_op("b2b second", 2'b00, 16'd7, 16'd9, 2'd3, 16'd63, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
